conv_window_sequencer: RTL and testbench

- Controls the 4096x8 single-port image RAM (12-bit address, registered read with 1-cycle latency) for 3x3 convolution.
- Scans a row-major IMG_W x IMG_H image at IN_BASE and streams the 9 pixels of each window, tagged by tap index, to the MAC datapath.
- Collects one 8-bit result per window and writes it back to the same RAM at OUT_BASE.
- It is the only RAM master while busy.

---
 rtl/conv_pkg.sv | 34 +++
 rtl/conv_addr_gen.sv | 48 ++++
 rtl/conv_window_sequencer.sv | 162 ++++++++++++++++
 tb/tb_conv_window_sequencer.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// Shared widths, FSM state encoding and tap-offset helpers for the 3x3 convolution window sequencer.
package conv_pkg;

  localparam int unsigned ADDR_W   = 12;
  localparam int unsigned DATA_W   = 8;
  localparam int unsigned NUM_TAPS = 9;
  localparam int unsigned TAP_W    = 4;

  localparam logic [TAP_W-1:0] LAST_TAP = TAP_W'(NUM_TAPS - 1);

  typedef enum logic [2:0] {
    IDLE,
    READ,
    WAIT_RES,
    WRITE,
    DONE
  } state_t;

  // Row offset of a tap inside the 3x3 window (tap = 3*dy + dx).
  function automatic logic [1:0] tap_dy(input logic [TAP_W-1:0] tap);
    if (tap < TAP_W'(3))      return 2'd0;
    else if (tap < TAP_W'(6)) return 2'd1;
    else                      return 2'd2;
  endfunction

  function automatic logic [1:0] tap_dx(input logic [TAP_W-1:0] tap);
    case (tap)
      TAP_W'(1), TAP_W'(4), TAP_W'(7): return 2'd1;
      TAP_W'(2), TAP_W'(5), TAP_W'(8): return 2'd2;
      default:                         return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/conv_addr_gen.sv
// Combinational input/output RAM address generation for one window tap.
// CONV_ZERO_PAD_EN selects centred windows with an in-range flag for zero padding.
module conv_addr_gen
  import conv_pkg::*;
#(
  parameter int unsigned IMG_W    = 32,
`ifdef CONV_ZERO_PAD_EN
  parameter int unsigned IMG_H    = 32,
`endif
  parameter int unsigned IN_BASE  = 0,
  parameter int unsigned OUT_BASE = 1024
) (
  input  logic [ADDR_W-1:0] row,
  input  logic [ADDR_W-1:0] col,
  input  logic [TAP_W-1:0]  tap,
  output logic [ADDR_W-1:0] in_addr,
  output logic              in_range,
  output logic [ADDR_W-1:0] out_addr
);

  localparam logic [ADDR_W-1:0] W_A   = ADDR_W'(IMG_W);
  localparam logic [ADDR_W-1:0] IN_B  = ADDR_W'(IN_BASE);
  localparam logic [ADDR_W-1:0] OUT_B = ADDR_W'(OUT_BASE);
`ifdef CONV_ZERO_PAD_EN
  localparam logic [ADDR_W-1:0] H_A   = ADDR_W'(IMG_H);
  localparam logic [ADDR_W-1:0] OUT_W = ADDR_W'(IMG_W);
`else
  localparam logic [ADDR_W-1:0] OUT_W = ADDR_W'(IMG_W - 2);
`endif

  logic [ADDR_W-1:0] rr;
  logic [ADDR_W-1:0] cc;

  always_comb begin
    rr = row + ADDR_W'(tap_dy(tap));
    cc = col + ADDR_W'(tap_dx(tap));
`ifdef CONV_ZERO_PAD_EN
    // rr/cc are pixel coordinates plus one, so 0 and IMG+1 fall outside the image.
    in_range = (rr != '0) && (rr <= H_A) && (cc != '0) && (cc <= W_A);
    in_addr  = IN_B + (rr - ADDR_W'(1)) * W_A + (cc - ADDR_W'(1));
`else
    in_range = 1'b1;
    in_addr  = IN_B + rr * W_A + cc;
`endif
    out_addr = OUT_B + row * OUT_W + col;
  end

endmodule

// File: rtl/conv_window_sequencer.sv
// RAM master that streams 3x3 windows to the MAC and writes each result back.
// CONV_ZERO_PAD_EN enables same-size output with zero-padded border taps.
module conv_window_sequencer
  import conv_pkg::*;
#(
  parameter int unsigned IMG_W    = 32,
  parameter int unsigned IMG_H    = 32,
  parameter int unsigned IN_BASE  = 0,
  parameter int unsigned OUT_BASE = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              ram_w_en,
  output logic              ram_r_en,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              pix_valid,
  output logic [DATA_W-1:0] pix_data,
  output logic [TAP_W-1:0]  pix_tap,
  output logic              pix_last,
  input  logic              res_valid,
  input  logic [DATA_W-1:0] res_data,
  output logic              res_ready
);

`ifdef CONV_ZERO_PAD_EN
  localparam int unsigned COLS = IMG_W;
  localparam int unsigned ROWS = IMG_H;
`else
  localparam int unsigned COLS = IMG_W - 2;
  localparam int unsigned ROWS = IMG_H - 2;
`endif
  localparam logic [ADDR_W-1:0] LAST_COL = ADDR_W'(COLS - 1);
  localparam logic [ADDR_W-1:0] LAST_ROW = ADDR_W'(ROWS - 1);

  state_t            state, nxt_state;
  logic [ADDR_W-1:0] row, col, nxt_row, nxt_col;
  logic [TAP_W-1:0]  tap, nxt_tap;
  logic [DATA_W-1:0] result, nxt_result;
  logic [ADDR_W-1:0] in_addr, out_addr;
  logic              in_range;

  // Next state and counters; outputs are registered from these next values.
  always_comb begin
    nxt_state  = state;
    nxt_row    = row;
    nxt_col    = col;
    nxt_tap    = tap;
    nxt_result = result;
    case (state)
      IDLE: begin
        if (start) begin
          nxt_state = READ;
          nxt_row   = '0;
          nxt_col   = '0;
          nxt_tap   = '0;
        end
      end
      READ: begin
        if (tap == LAST_TAP) begin
          nxt_state = WAIT_RES;
          nxt_tap   = '0;
        end else begin
          nxt_tap = tap + TAP_W'(1);
        end
      end
      WAIT_RES: begin
        if (res_valid) begin
          nxt_result = res_data;
          nxt_state  = WRITE;
        end
      end
      WRITE: begin
        if (col == LAST_COL) begin
          nxt_col = '0;
          nxt_row = row + ADDR_W'(1);
        end else begin
          nxt_col = col + ADDR_W'(1);
        end
        nxt_state = ((row == LAST_ROW) && (col == LAST_COL)) ? DONE : READ;
      end
      DONE:    nxt_state = IDLE;
      default: nxt_state = IDLE;
    endcase
  end

  conv_addr_gen #(
    .IMG_W    (IMG_W),
`ifdef CONV_ZERO_PAD_EN
    .IMG_H    (IMG_H),
`endif
    .IN_BASE  (IN_BASE),
    .OUT_BASE (OUT_BASE)
  ) u_addr_gen (
    .row      (nxt_row),
    .col      (nxt_col),
    .tap      (nxt_tap),
    .in_addr  (in_addr),
    .in_range (in_range),
    .out_addr (out_addr)
  );

`ifdef CONV_ZERO_PAD_EN
  logic pix_rd;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      row       <= '0;
      col       <= '0;
      tap       <= '0;
      result    <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      res_ready <= 1'b0;
      ram_r_en  <= 1'b0;
      ram_w_en  <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= '0;
      pix_valid <= 1'b0;
      pix_tap   <= '0;
      pix_last  <= 1'b0;
`ifdef CONV_ZERO_PAD_EN
      pix_rd    <= 1'b0;
`endif
    end else begin
      state     <= nxt_state;
      row       <= nxt_row;
      col       <= nxt_col;
      tap       <= nxt_tap;
      result    <= nxt_result;
      busy      <= (nxt_state != IDLE);
      done      <= (nxt_state == DONE);
      res_ready <= (nxt_state == WAIT_RES);
      ram_r_en  <= (nxt_state == READ) && in_range;
      ram_w_en  <= (nxt_state == WRITE);
      ram_wdata <= (nxt_state == WRITE) ? nxt_result : '0;
      if ((nxt_state == READ) && in_range) ram_addr <= in_addr;
      else if (nxt_state == WRITE)         ram_addr <= out_addr;
      else                                 ram_addr <= '0;
      // Pixel tags lag the read issue by one cycle to line up with RAM data.
      pix_valid <= (state == READ);
      pix_tap   <= (state == READ) ? tap : '0;
      pix_last  <= (state == READ) && (tap == LAST_TAP);
`ifdef CONV_ZERO_PAD_EN
      pix_rd    <= ram_r_en;
`endif
    end
  end

`ifdef CONV_ZERO_PAD_EN
  assign pix_data = pix_rd ? ram_rdata : '0;
`else
  assign pix_data = pix_valid ? ram_rdata : '0;
`endif

endmodule

// File: tb/tb_conv_window_sequencer.sv
// Self-checking bench for conv_window_sequencer on a 4x4 image with a RAM model and a summing MAC model.
module tb_conv_window_sequencer;

  localparam int unsigned W    = 4;
  localparam int unsigned H    = 4;
  localparam int unsigned INB  = 0;
  localparam int unsigned OUTB = 1024;
`ifdef CONV_ZERO_PAD_EN
  localparam bit PAD = 1'b1;
`else
  localparam bit PAD = 1'b0;
`endif
  localparam int unsigned OW   = PAD ? W : W - 2;
  localparam int unsigned OH   = PAD ? H : H - 2;
  localparam int unsigned NWIN = OW * OH;

  logic        clk = 1'b0;
  logic        rst_n, start;
  logic        busy, done, ram_w_en, ram_r_en, pix_valid, pix_last, res_ready;
  logic [11:0] ram_addr;
  logic [7:0]  ram_wdata, ram_rdata, pix_data;
  logic [3:0]  pix_tap;
  logic        res_valid = 1'b0;
  logic [7:0]  res_data = 8'h00;

  int checks = 0;
  int failures = 0;

  conv_window_sequencer #(.IMG_W(W), .IMG_H(H), .IN_BASE(INB), .OUT_BASE(OUTB)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
    .ram_w_en(ram_w_en), .ram_r_en(ram_r_en), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .pix_valid(pix_valid), .pix_data(pix_data), .pix_tap(pix_tap), .pix_last(pix_last),
    .res_valid(res_valid), .res_data(res_data), .res_ready(res_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Single-port RAM with one-cycle registered read.
  logic [7:0] mem [4096];
  always @(posedge clk) begin
    if (ram_r_en) ram_rdata <= mem[ram_addr];
    if (ram_w_en) mem[ram_addr] <= ram_wdata;
  end

  // Observation logs and per-cycle protocol rules.
  int cyc = 0;
  int rd_log[$], tap_q[$], dat_q[$], last_q[$], wr_cyc[$], wr_addr[$];
  int n_done = 0;
  int rr_cycles = 0;
  bit acc_prev = 1'b0;
  always @(negedge clk) begin
    cyc++;
    if (rst_n) begin
      if (ram_r_en) rd_log.push_back(int'(ram_addr));
      if (pix_valid) begin
        tap_q.push_back(int'(pix_tap));
        dat_q.push_back(int'(pix_data));
        last_q.push_back(int'(pix_last));
      end
      if (ram_w_en) begin
        wr_cyc.push_back(cyc);
        wr_addr.push_back(int'(ram_addr));
      end
      if (done) n_done++;
      if (res_ready) rr_cycles++;
      chk("en_exclusive", 64'(ram_r_en & ram_w_en), 64'd0);
      if (!ram_r_en && !ram_w_en) chk("addr_idle_zero", 64'(ram_addr), 64'd0);
      if (res_ready) chk("wait_no_enables", 64'({ram_r_en, ram_w_en}), 64'd0);
      if (acc_prev) chk("write_after_res", 64'(ram_w_en), 64'd1);
      acc_prev = res_valid && res_ready;
    end else begin
      acc_prev = 1'b0;
    end
  end

  // MAC model: sums the nine pixels mod 256 and answers after dly[window] cycles.
  int dly [NWIN];
  int mac_win = 0;
  int acc = 0;
  int cnt = 0;
  bit pend = 1'b0;
  bit stray_armed = 1'b0;
  logic [7:0] sum_q = 8'h00;
  always @(negedge clk) begin
    res_valid = 1'b0;
    if (!rst_n) begin
      pend = 1'b0;
      acc  = 0;
    end else begin
      if (pend) begin
        if (cnt == 0) begin
          res_valid = 1'b1;
          res_data  = sum_q;
          pend      = 1'b0;
        end else cnt--;
      end
      if (pix_valid) begin
        acc += int'(pix_data);
        if (pix_last) begin
          sum_q = 8'(acc);
          acc = 0;
          if (mac_win < NWIN && dly[mac_win] == 0) begin
            res_valid = 1'b1;
            res_data  = sum_q;
          end else begin
            pend = 1'b1;
            cnt  = (mac_win < NWIN) ? dly[mac_win] - 1 : 0;
          end
          mac_win++;
        end
      end
      if (stray_armed && ram_r_en && wr_cyc.size() == 2) begin
        res_valid   = 1'b1;
        res_data    = 8'hEE;
        stray_armed = 1'b0;
      end
    end
  end

  // Reference model: window list from coordinates, independent of the RTL counters.
  int e_rd[$], e_tap[$], e_dat[$];
  int e_res [NWIN];
  function automatic void build_model();
    int s, pr, pc, a, v;
    e_rd.delete(); e_tap.delete(); e_dat.delete();
    for (int r = 0; r < int'(OH); r++) begin
      for (int c = 0; c < int'(OW); c++) begin
        s = 0;
        for (int t = 0; t < 9; t++) begin
          pr = r + t / 3 - (PAD ? 1 : 0);
          pc = c + t % 3 - (PAD ? 1 : 0);
          if (pr >= 0 && pr < int'(H) && pc >= 0 && pc < int'(W)) begin
            a = (int'(INB) + pr * int'(W) + pc) % 4096;
            e_rd.push_back(a);
            v = int'(mem[a]);
          end else v = 0;
          e_tap.push_back(t);
          e_dat.push_back(v);
          s += v;
        end
        e_res[r * int'(OW) + c] = s % 256;
      end
    end
  endfunction

  task automatic run_frame(input string tag, input bit stray);
    int start_cyc, prev, mm, exp_rr;
    bit got;
    build_model();
    rd_log.delete(); tap_q.delete(); dat_q.delete(); last_q.delete();
    wr_cyc.delete(); wr_addr.delete();
    n_done = 0; rr_cycles = 0; mac_win = 0; acc = 0; pend = 1'b0;
    stray_armed = stray;
    start = 1'b1;
    start_cyc = cyc;
    got = 1'b0;
    for (int i = 0; i < 4000 && !got; i++) begin
      @(negedge clk); #1;
      start = (stray && cyc == start_cyc + 14);
      if (n_done > 0) got = 1'b1;
    end
    chk({tag, "_done_seen"}, 64'(got), 64'd1);
    chk({tag, "_busy_in_done"}, 64'(busy), 64'd1);
    @(negedge clk); #1;
    chk({tag, "_busy_after_done"}, 64'({busy, done}), 64'd0);
    repeat (3) @(negedge clk);
    #1;
    chk({tag, "_done_count"}, 64'(n_done), 64'd1);
    chk({tag, "_write_count"}, 64'(wr_cyc.size()), 64'(NWIN));
    chk({tag, "_read_count"}, 64'(rd_log.size()), 64'(e_rd.size()));
    mm = 0;
    for (int i = 0; i < rd_log.size() && i < e_rd.size(); i++) if (rd_log[i] != e_rd[i]) mm++;
    chk({tag, "_read_addrs"}, 64'(mm), 64'd0);
    chk({tag, "_pix_count"}, 64'(tap_q.size()), 64'(e_tap.size()));
    mm = 0;
    for (int i = 0; i < tap_q.size() && i < e_tap.size(); i++)
      if (tap_q[i] != e_tap[i] || dat_q[i] != e_dat[i] || last_q[i] != int'(e_tap[i] == 8)) mm++;
    chk({tag, "_pix_stream"}, 64'(mm), 64'd0);
    exp_rr = 0;
    prev = start_cyc;
    for (int k = 0; k < int'(NWIN) && k < wr_cyc.size(); k++) begin
      chk($sformatf("%s_gap%0d", tag, k), 64'(wr_cyc[k] - prev), 64'(11 + dly[k]));
      chk($sformatf("%s_waddr%0d", tag, k), 64'(wr_addr[k]), 64'(int'(OUTB) + k));
      chk($sformatf("%s_res%0d", tag, k), 64'(mem[int'(OUTB) + k]), 64'(e_res[k]));
      prev = wr_cyc[k];
      exp_rr += dly[k] + 1;
    end
    chk({tag, "_wait_cycles"}, 64'(rr_cycles), 64'(exp_rr));
  endtask

  initial begin
    bit hit;
    int win_a [4];
    rst_n = 1'b0;
    start = 1'b0;
    for (int i = 0; i < 4096; i++) mem[i] = 8'(i);
    for (int k = 0; k < int'(NWIN); k++) dly[k] = 1;
    dly[1] = 20;
    repeat (3) @(negedge clk);
    #1;
    chk("reset_outputs", 64'({busy, done, ram_w_en, ram_r_en, ram_addr, ram_wdata, pix_valid,
                              pix_data, pix_tap, pix_last, res_ready}), 64'd0);
    rst_n = 1'b1;
    @(negedge clk); #1;
    chk("idle_not_busy", 64'(busy), 64'd0);

    // Frame A: ramp image, long MAC stall in window 1, stray start and stray res_valid.
    run_frame("A", 1'b1);
`ifndef CONV_ZERO_PAD_EN
    win_a = '{45, 54, 81, 90};
    for (int k = 0; k < 4; k++) chk($sformatf("A_known%0d", k), 64'(mem[int'(OUTB) + k]), 64'(win_a[k]));
`endif

    // Frame B: random image and random MAC latency 0..3.
    for (int i = 0; i < int'(W * H); i++) mem[int'(INB) + i] = 8'($urandom);
    for (int k = 0; k < int'(NWIN); k++) dly[k] = int'($urandom_range(0, 3));
    run_frame("B", 1'b0);

    // Abort: reset asserted during the write of window 2.
    mem[int'(OUTB) + 2] = 8'h5A;
    for (int k = 0; k < int'(NWIN); k++) dly[k] = 1;
    mac_win = 0; n_done = 0;
    start = 1'b1;
    @(negedge clk); #1;
    start = 1'b0;
    hit = 1'b0;
    for (int i = 0; i < 2000 && !hit; i++) begin
      @(negedge clk); #1;
      if (ram_w_en && ram_addr == 12'(OUTB + 2)) hit = 1'b1;
    end
    chk("abort_reached_write2", 64'(hit), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("abort_outputs_zero", 64'({busy, done, ram_w_en, ram_r_en, ram_addr, ram_wdata, pix_valid,
                                   pix_data, pix_tap, pix_last, res_ready}), 64'd0);
    repeat (3) @(negedge clk);
    #1;
    chk("abort_ram_untouched", 64'(mem[int'(OUTB) + 2]), 64'h5A);
    chk("abort_no_done", 64'(n_done), 64'd0);
    rst_n = 1'b1;
    @(negedge clk); #1;

    // Frame C: restart after the abort must begin again at window 0.
    for (int i = 0; i < int'(W * H); i++) mem[int'(INB) + i] = 8'($urandom);
    for (int k = 0; k < int'(NWIN); k++) dly[k] = int'($urandom_range(0, 2));
    run_frame("C", 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
